// File: rtl/data_mem_pkg.sv
// Shared constants for the data memory and the arbiter that fronts it.
package data_mem_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 8;
  localparam int DMEM_DEPTH  = 192;

  localparam int PORT_CORE = 0;
  localparam int PORT_DMA  = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a one-cycle-renewable lock.
// Grant is combinational; last_winner and lock ownership are flopped.
module rr_arb2
  import data_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt,
  output logic       winner
);

  logic last_winner;
  logic lock_vld;
  logic lock_owner;

  always_comb begin
    gnt = 2'b00;
    if (lock_vld && req[lock_owner]) begin
      gnt[lock_owner] = 1'b1;
    end else if (req == 2'b11) begin
      gnt[~last_winner] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  assign winner = gnt[PORT_DMA];

  // Lock only survives while its owner keeps winning; any idle cycle or
  // a grant without lock releases it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_winner <= 1'b1;
      lock_vld    <= 1'b0;
      lock_owner  <= 1'b0;
    end else if (|gnt) begin
      last_winner <= winner;
      lock_vld    <= lock[winner];
      lock_owner  <= winner;
    end else begin
      lock_vld    <= 1'b0;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates two requesters onto the single-port data memory, range-checks
// addresses and routes the registered read data back to the owning port.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        gnt;
  logic              winner;
  logic              has_win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              in_range;
  logic              rd_oor;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1, req0}),
    .lock   ({lock1, lock0}),
    .gnt    (gnt),
    .winner (winner)
  );

  assign gnt0    = gnt[PORT_CORE];
  assign gnt1    = gnt[PORT_DMA];
  assign has_win = |gnt;

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (has_win) begin
      win_we    = winner ? we1    : we0;
      win_addr  = winner ? addr1  : addr0;
      win_wdata = winner ? wdata1 : wdata0;
    end
  end

  assign in_range  = ({1'b0, win_addr} < DEPTH_C);
  assign mem_addr  = win_addr;
  assign mem_wdata = win_wdata;
  assign mem_we    = has_win & win_we & in_range;

  // Only one access is granted per cycle, so a single out-of-range flag
  // covers whichever port owns the returning read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rd_oor  <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      err0    <= gnt0 & ~in_range;
      err1    <= gnt1 & ~in_range;
      rd_oor  <= ~in_range;
    end
  end

  assign rdata0 = (rvalid0 && !rd_oor) ? mem_rdata : '0;
  assign rdata1 = (rvalid1 && !rd_oor) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 192x8 memory
// preloaded with addr ^ 8'h5A.
module tb_data_mem_arbiter;

  logic       clk;
  logic       reset;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;

  int n_chk;
  int n_pass;

  logic [7:0] mem [0:191];

  data_mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .lock0     (lock0),
    .lock1     (lock1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .err0      (err0),
    .err1      (err1),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we && mem_addr < 8'd192) mem[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_addr < 8'd192) ? mem[mem_addr] : 8'hEE;
  end

  typedef struct {
    logic       req0, we0, lock0;
    logic [7:0] addr0, wd0;
    logic       req1, we1, lock1;
    logic [7:0] addr1, wd1;
    logic       g0, g1, mwe;
    logic [7:0] maddr, mwd;
    logic       rv0, e0;
    logic [7:0] rd0;
    logic       rv1, e1;
    logic [7:0] rd1;
  } vec_t;

  vec_t vecs [0:21];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    for (int i = 0; i < 192; i++) mem[i] <= 8'(i) ^ 8'h5A;

    //           req0 we0 lk0 addr0  wd0    req1 we1 lk1 addr1  wd1    g0 g1 mwe maddr  mwd    rv0 e0 rd0    rv1 e1 rd1
    vecs[0]  = '{1, 1, 0, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 0, 0, 8'h00};
    vecs[1]  = '{1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00};
    vecs[2]  = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h03, 8'h00, 0, 1, 0, 8'h03, 8'h00, 1, 0, 8'hA5, 0, 0, 8'h00};
    vecs[3]  = '{1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 1, 0, 0, 8'h01, 8'h00, 0, 0, 8'h00, 1, 0, 8'h59};
    vecs[4]  = '{1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 0, 1, 0, 8'h02, 8'h00, 1, 0, 8'h5B, 0, 0, 8'h00};
    vecs[5]  = '{1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 1, 0, 0, 8'h01, 8'h00, 0, 0, 8'h00, 1, 0, 8'h58};
    vecs[6]  = '{1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 0, 1, 0, 8'h02, 8'h00, 1, 0, 8'h5B, 0, 0, 8'h00};
    vecs[7]  = '{1, 0, 0, 8'h01, 8'h00, 1, 0, 1, 8'h02, 8'h00, 1, 0, 0, 8'h01, 8'h00, 0, 0, 8'h00, 1, 0, 8'h58};
    vecs[8]  = '{1, 0, 0, 8'h01, 8'h00, 1, 0, 1, 8'h02, 8'h00, 0, 1, 0, 8'h02, 8'h00, 1, 0, 8'h5B, 0, 0, 8'h00};
    vecs[9]  = '{1, 0, 0, 8'h01, 8'h00, 1, 0, 1, 8'h02, 8'h00, 0, 1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 1, 0, 8'h58};
    vecs[10] = '{1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 0, 1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 1, 0, 8'h58};
    vecs[11] = '{1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 1, 0, 0, 8'h01, 8'h00, 0, 0, 8'h00, 1, 0, 8'h58};
    vecs[12] = '{0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'hC0, 8'hFF, 0, 1, 0, 8'hC0, 8'hFF, 1, 0, 8'h5B, 0, 0, 8'h00};
    vecs[13] = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'hBF, 8'h00, 0, 1, 0, 8'hBF, 8'h00, 0, 0, 8'h00, 0, 1, 8'h00};
    vecs[14] = '{1, 0, 0, 8'hC8, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'hC8, 8'h00, 0, 0, 8'h00, 1, 0, 8'hE5};
    vecs[15] = '{1, 1, 0, 8'h21, 8'h44, 1, 1, 1, 8'h20, 8'h33, 0, 1, 1, 8'h20, 8'h33, 1, 1, 8'h00, 0, 0, 8'h00};
    vecs[16] = '{1, 1, 0, 8'h21, 8'h44, 1, 1, 1, 8'h22, 8'h55, 0, 1, 1, 8'h22, 8'h55, 0, 0, 8'h00, 0, 0, 8'h00};
    vecs[17] = '{0, 1, 0, 8'h21, 8'h44, 1, 0, 0, 8'h20, 8'h00, 0, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00};
    vecs[18] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 8'h33};
    vecs[19] = '{1, 0, 0, 8'h21, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h21, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00};
    vecs[20] = '{1, 0, 0, 8'h22, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h22, 8'h00, 1, 0, 8'h7B, 0, 0, 8'h00};
    vecs[21] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h55, 0, 0, 8'h00};

    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #2;
    chk1("reset rvalid0", rvalid0, 1'b0);
    chk1("reset rvalid1", rvalid1, 1'b0);
    chk1("reset err0", err0, 1'b0);
    chk1("reset err1", err1, 1'b0);
    chk8("reset mem_addr", mem_addr, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      req0 = vecs[i].req0; we0 = vecs[i].we0; lock0 = vecs[i].lock0;
      addr0 = vecs[i].addr0; wdata0 = vecs[i].wd0;
      req1 = vecs[i].req1; we1 = vecs[i].we1; lock1 = vecs[i].lock1;
      addr1 = vecs[i].addr1; wdata1 = vecs[i].wd1;
      #2;
      chk1($sformatf("v%0d gnt0", i), gnt0, vecs[i].g0);
      chk1($sformatf("v%0d gnt1", i), gnt1, vecs[i].g1);
      chk1($sformatf("v%0d mem_we", i), mem_we, vecs[i].mwe);
      chk8($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].maddr);
      chk8($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].mwd);
      chk1($sformatf("v%0d rvalid0", i), rvalid0, vecs[i].rv0);
      chk1($sformatf("v%0d err0", i), err0, vecs[i].e0);
      chk8($sformatf("v%0d rdata0", i), rdata0, vecs[i].rd0);
      chk1($sformatf("v%0d rvalid1", i), rvalid1, vecs[i].rv1);
      chk1($sformatf("v%0d err1", i), err1, vecs[i].e1);
      chk8($sformatf("v%0d rdata1", i), rdata1, vecs[i].rd1);
    end

    // Reset lands while a locked port-1 read is returning.
    @(negedge clk);
    idle_inputs();
    req1 = 1; addr1 = 8'h05; lock1 = 1;
    #2;
    chk1("rst seq gnt1", gnt1, 1'b1);
    @(posedge clk);
    #1;
    chk1("rst seq rvalid1 before reset", rvalid1, 1'b1);
    reset = 1'b1;
    #1;
    chk1("rst seq rvalid1 async clear", rvalid1, 1'b0);
    chk1("rst seq rvalid0 async clear", rvalid0, 1'b0);
    chk1("rst seq err1 async clear", err1, 1'b0);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    req0 = 1; addr0 = 8'h06;
    req1 = 1; addr1 = 8'h07;
    #2;
    chk1("post-reset gnt0", gnt0, 1'b1);
    chk1("post-reset gnt1", gnt1, 1'b0);
    chk1("post-reset rvalid1", rvalid1, 1'b0);
    @(negedge clk);
    idle_inputs();
    #2;
    chk1("post-reset rvalid0", rvalid0, 1'b1);
    chk8("post-reset rdata0", rdata0, 8'h5C);
    chk1("post-reset rvalid1 idle", rvalid1, 1'b0);
    chk8("post-reset rdata1", rdata1, 8'h00);

    // Port 0 read return coincides with a new port 0 write grant.
    @(negedge clk);
    req0 = 1; addr0 = 8'h30;
    #2;
    chk1("overlap gnt0 read", gnt0, 1'b1);
    @(negedge clk);
    we0 = 1; addr0 = 8'h31; wdata0 = 8'h9C;
    #2;
    chk1("overlap gnt0 write", gnt0, 1'b1);
    chk1("overlap mem_we", mem_we, 1'b1);
    chk1("overlap rvalid0", rvalid0, 1'b1);
    chk8("overlap rdata0", rdata0, 8'h6A);
    @(negedge clk);
    idle_inputs();
    #2;
    chk1("overlap write no rvalid0", rvalid0, 1'b0);
    chk1("overlap write no err0", err0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port data_memory (8-bit address, 192 x 8-bit lines, synchronous write, 1-cycle registered read) between port 0 (core load/store unit) and port 1 (DMA/block-copy engine).
- Performs round-robin grant with optional lock, range-checks addresses against DEPTH, and returns read data with a 1-cycle valid strobe to the owning requester.
- Sits between the requesters and the memory instance; it is the only driver of the memory's address, write_data and write_enable.

Parameters:
- ADDR_W, 8, address width; matches data_memory address port.
- DATA_W, 8, data width.
- DEPTH, 192, number of legal memory lines; an address >= DEPTH is out of range.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req0, req1  in  1  access request from port 0 / port 1.
- we0, we1  in  1  1 = write, 0 = read, per port.
- addr0, addr1  in  ADDR_W  address per port.
- wdata0, wdata1  in  DATA_W  write data per port.
- lock0, lock1  in  1  keep priority for the next cycle if granted this cycle.
- gnt0, gnt1  out  1  combinational grant; the access is taken this cycle.
- rvalid0, rvalid1  out  1  read data valid, registered.
- rdata0, rdata1  out  DATA_W  read data; meaningful only while the matching rvalid is high.
- err0, err1  out  1  out-of-range strobe, registered, coincident with rvalid or the write-completion cycle.
- mem_addr  out  ADDR_W  to data_memory data_address.
- mem_wdata  out  DATA_W  to data_memory write_data.
- mem_we  out  1  to data_memory write_enable.
- mem_rdata  in  DATA_W  from data_memory read_data.

Behaviour:
- Reset (async, active-high): last_winner=1, so port 0 wins first. lock_owner cleared. All rvalid* and err* = 0. Pending read tag cleared. A read in flight when reset asserts is dropped and no rvalid is issued.
- Arbitration (combinational, cycle N):
  - Exactly one gnt at most per cycle. gnt is never asserted without its req.
  - If lock_owner is valid and that port requests, it wins.
  - Otherwise, with a single requester, that port wins.
  - With both requesting, the port != last_winner wins.
  - On a winner, update last_winner at posedge.
  - lock_owner <= winner if that port's lock is high, else cleared.
  - If lock is held but the owner does not request, the lock is cleared and normal round-robin applies.
- Memory drive, cycle N:
  - mem_addr and mem_wdata come from the winner; when there is no winner they are 0.
  - mem_we = winner's we AND in_range.
  - in_range = addr < DEPTH.
  - Out-of-range accesses are granted but never reach memory (mem_we=0).
- Read return:
  - A granted in-range read at N gives rvalid_x=1 at N+1, with rdata_x = mem_rdata (passthrough of the memory's registered output).
  - A granted out-of-range read gives rvalid_x=1 and err_x=1 at N+1, with rdata_x=0.
  - rdata of the non-owning port is 0.
- Write completion: a granted write has no rvalid. err_x=1 at N+1 only if the write was out of range.
- Back-to-back: a new grant is allowed every cycle, including a read followed by a read, or a write immediately followed by a read of the same address.
  - The memory applies the write at the N edge and the read at the N+1 edge, so the read returns the new data at N+2.
- A requester must hold req/we/addr/wdata stable until it sees gnt. Dropping req before gnt is legal and simply withdraws the request.
- Simultaneous events: rvalid for a previous read and gnt for a new access on the same port in one cycle are legal and independent.

Decomposition:
- Shared package data_mem_pkg:
  - constants DMEM_ADDR_W=8, DMEM_DATA_W=8, DMEM_DEPTH=192.
  - port index constants PORT_CORE=0, PORT_DMA=1.
- One natural sub-module: rr_arb2 (2-way round-robin with lock; combinational grant plus last_winner/lock_owner flops).
- Range check, mux and return-path registers stay in the top.

Test Plan:
- Reset release, then req0 write addr=8'h10 wdata=8'hA5, then read addr=8'h10 -> gnt0 both cycles; rvalid0=1, rdata0=8'hA5 two cycles after the write's grant; rvalid1 stays 0.
- req0 and req1 both read every cycle for 4 cycles -> grants alternate 0,1,0,1; each rvalid follows its grant by exactly 1 cycle.
- lock1=1 with both requesting for 3 cycles -> gnt1 three consecutive cycles; lock1 dropped -> next grant to port 0.
- req1 write addr=8'd192 wdata=8'hFF -> gnt1=1, mem_we=0, err1=1 next cycle. A subsequent read of addr 8'd191 returns its prior contents, unchanged.
- reset asserted the cycle after a granted read -> rvalid0/rvalid1 forced 0 immediately (async). After release, port 0 wins a simultaneous request.
- req0 dropped before grant while port 1 is locked -> no gnt0 and no mem_we from port 0.
